multicycle_main_control: RTL and testbench

//  Main control FSM of the multicycle MIPS datapath. Sits directly upstream of the ALU decoder.

---
 rtl/multicycle_main_control.sv | 146 ++++++++++++++
 tb/tb_multicycle_main_control.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects and write enables.
module multicycle_main_control (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    output logic       iord_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       pc_en_o,
    output logic       illegal_op_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (op_i)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (op_i == OpLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWb;
            StExecute: state_d = StAluWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    logic ir_write, reg_write, mem_write, pc_write, branch;

    always_comb begin
        iord_o       = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        pc_src_o     = 2'b00;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        illegal_op_o = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        case (state_q)
            StFetch: begin
                alu_src_b_o = 2'b01;
                ir_write    = 1'b1;
                pc_write    = 1'b1;
            end
            StDecode: begin
                alu_src_b_o  = 2'b11;
                illegal_op_o = !(op_i inside {OpRtype, OpLw, OpSw, OpBeq, OpAddi, OpJ});
            end
            StMemAdr, StAddiEx: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            StMemRd: iord_o = 1'b1;
            StMemWr: begin
                iord_o    = 1'b1;
                mem_write = 1'b1;
            end
            StMemWb: begin
                mem_to_reg_o = 1'b1;
                reg_write    = 1'b1;
            end
            StExecute: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b10;
            end
            StAluWb: begin
                reg_dst_o = 1'b1;
                reg_write = 1'b1;
            end
            StAddiWb: reg_write = 1'b1;
            StBranch: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b01;
                pc_src_o    = 2'b01;
                branch      = 1'b1;
            end
            StJump: begin
                pc_src_o = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by the raw reset so nothing writes while reset is held.
    assign ir_write_o  = rst_ni & ir_write;
    assign reg_write_o = rst_ni & reg_write;
    assign mem_write_o = rst_ni & mem_write;
    assign pc_en_o     = rst_ni & (pc_write | (branch & zero_i));
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: per-cycle expected output vectors are queued
// from an independent state table and compared against the DUT half a cycle after each edge.
module tb_multicycle_main_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       iord, src_a, reg_dst, m2r, ir_w, reg_w, mem_w, pc_en, illegal;
    logic [1:0] src_b, alu_op, pc_src;
    logic [3:0] state;

    int vectors     = 0;
    int miscompares = 0;
    logic [18:0] exp_q[$];

    multicycle_main_control dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .op_i        (op),
        .zero_i      (zero),
        .iord_o      (iord),
        .alu_src_a_o (src_a),
        .alu_src_b_o (src_b),
        .alu_op_o    (alu_op),
        .pc_src_o    (pc_src),
        .reg_dst_o   (reg_dst),
        .mem_to_reg_o(m2r),
        .ir_write_o  (ir_w),
        .reg_write_o (reg_w),
        .mem_write_o (mem_w),
        .pc_en_o     (pc_en),
        .illegal_op_o(illegal),
        .state_o     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {state, iord, srca, srcb, aluop, pcsrc, regdst, memtoreg, irwrite, regwrite, memwrite,
    //  pcen, illegal}
    wire [18:0] obs = {state, iord, src_a, src_b, alu_op, pc_src, reg_dst, m2r, ir_w, reg_w,
                       mem_w, pc_en, illegal};

    localparam logic [18:0] RstVec = {4'd0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 7'b0};

    function automatic logic [18:0] exp_vec(input logic [3:0] st, input logic [5:0] o,
                                            input logic z);
        logic       e_iord = 1'b0, e_srca = 1'b0, e_rd = 1'b0, e_m2r = 1'b0;
        logic       e_irw = 1'b0, e_rw = 1'b0, e_mw = 1'b0, e_pcen = 1'b0, e_ill = 1'b0;
        logic [1:0] e_srcb = 2'b00, e_aluop = 2'b00, e_pcsrc = 2'b00;
        case (st)
            4'd0: begin e_srcb = 2'b01; e_irw = 1'b1; e_pcen = 1'b1; end
            4'd1: begin
                e_srcb = 2'b11;
                e_ill  = !(o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
                           o == 6'b000100 || o == 6'b001000 || o == 6'b000010);
            end
            4'd2, 4'd9: begin e_srca = 1'b1; e_srcb = 2'b10; end
            4'd3: e_iord = 1'b1;
            4'd4: begin e_m2r = 1'b1; e_rw = 1'b1; end
            4'd5: begin e_iord = 1'b1; e_mw = 1'b1; end
            4'd6: begin e_srca = 1'b1; e_aluop = 2'b10; end
            4'd7: begin e_rd = 1'b1; e_rw = 1'b1; end
            4'd8: begin e_srca = 1'b1; e_aluop = 2'b01; e_pcsrc = 2'b01; e_pcen = z; end
            4'd10: e_rw = 1'b1;
            4'd11: begin e_pcsrc = 2'b10; e_pcen = 1'b1; end
            default: ;
        endcase
        return {st, e_iord, e_srca, e_srcb, e_aluop, e_pcsrc, e_rd, e_m2r, e_irw, e_rw, e_mw,
                e_pcen, e_ill};
    endfunction

    task automatic check_one(input string tag);
        logic [18:0] exp;
        #1;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %h with no expected vector queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // seq holds the expected state codes one per hex digit, first state in the top digit used.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic z,
                             input logic [23:0] seq, input int n);
        op   = o;
        zero = z;
        for (int i = 0; i < n; i++) exp_q.push_back(exp_vec(seq[4*(n-1-i) +: 4], o, z));
        for (int i = 0; i < n; i++) begin
            check_one(tag);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        op    = 6'b0;
        zero  = 1'b0;
        exp_q.push_back(RstVec);
        check_one("por_reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_instr("lw",      6'b100011, 1'b0, 24'h01234, 5);
        run_instr("sw",      6'b101011, 1'b0, 24'h0125,  4);
        run_instr("rtype",   6'b000000, 1'b1, 24'h0167,  4);
        run_instr("addi",    6'b001000, 1'b0, 24'h019A,  4);
        run_instr("beq_z1",  6'b000100, 1'b1, 24'h018,   3);
        run_instr("beq_z0",  6'b000100, 1'b0, 24'h018,   3);
        run_instr("j",       6'b000010, 1'b0, 24'h01B,   3);
        run_instr("illegal", 6'b111111, 1'b0, 24'h01,    2);

        // Abort an R-type mid-EXECUTE with an asynchronous reset.
        op   = 6'b000000;
        zero = 1'b1;
        exp_q.push_back(exp_vec(4'd0, op, zero));
        exp_q.push_back(exp_vec(4'd1, op, zero));
        exp_q.push_back(exp_vec(4'd6, op, zero));
        check_one("abort_fetch");
        @(negedge clk);
        check_one("abort_decode");
        @(negedge clk);
        check_one("abort_execute");
        rst_n = 1'b0;
        exp_q.push_back(RstVec);
        check_one("async_reset");
        @(posedge clk);
        exp_q.push_back(RstVec);
        check_one("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        run_instr("post_reset_rtype", 6'b000000, 1'b0, 24'h0167, 4);

        exp_q.push_back(exp_vec(4'd0, op, zero));
        check_one("final_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no completion, required finish within 20000 time units");
        $fatal(1, "timeout");
    end

endmodule
